// File: rtl/display_scan_ctrl_pkg.sv
// Purpose : shared constants and the leading-zero helper for the display scan controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package display_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int DISP_W     = NUM_DIGITS * DIGIT_W;
  localparam int SEL_W      = $clog2(NUM_DIGITS);

  // True when digit 'sel' and every more-significant digit of 'd' are zero.
  // Digit 0 always reports false so an all-zero value still shows one "0".
  function automatic logic is_lead_zero(input logic [DISP_W-1:0] d,
                                        input logic [SEL_W-1:0]  sel);
    logic z;
    z = (sel != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(sel) && d[k*DIGIT_W +: DIGIT_W] != '0) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_refresh_prescaler.sv
// Purpose : free-running 0..DIV-1 counter that marks the last cycle of each digit slot.
// Latency : tc is combinational from the registered count (asserted during count DIV-1).
// Backpressure: enable=0 freezes the count and suppresses tc.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous reset, active-low
//   enable  in  1 = count, 0 = hold
//   tc      out high for the one cycle in which the count sits at DIV-1 (enabled)
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Purpose : 4-digit 7-segment scan controller; frame-aligned value updates, digit select, blanking.
// Latency : select/digit_tick/frame_done one cycle after terminal count; load -> bin <= 1 frame + 1 slot.
// Backpressure: none; enable=0 freezes scanning but load is still captured.
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   enable       run the scan (0 = prescaler, select and disp hold)
//   value, load  16-bit display value and its 1-cycle capture strobe
//   lz_blank_en  flag leading-zero digits on blank
//   bin, select  current nibble and digit index (0 = rightmost)
//   blank        current digit is a leading zero
//   digit_tick   pulse when select advances
//   frame_done   pulse when select wraps 3 -> 0
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DISP_W-1:0]  value,
  input  logic               load,
  input  logic               lz_blank_en,
  output logic [DIGIT_W-1:0] bin,
  output logic [SEL_W-1:0]   select,
  output logic               blank,
  output logic               digit_tick,
  output logic               frame_done
);

  logic              tc;
  logic              boundary;
  logic [SEL_W-1:0]  sel_q;
  logic [DISP_W-1:0] shadow;
  logic [DISP_W-1:0] disp;
  logic              pending;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tc     (tc)
  );

  // Last cycle of the last digit slot: the only point disp may change.
  assign boundary = tc && (sel_q == SEL_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      digit_tick <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      digit_tick <= tc;
      frame_done <= boundary;
      if (tc) begin
        sel_q <= sel_q + SEL_W'(1);
      end
      // A load landing on the boundary goes straight to disp rather than
      // waiting out a whole frame in the shadow register.
      if (boundary && load) begin
        disp    <= value;
        shadow  <= value;
        pending <= 1'b0;
      end else if (boundary && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

  assign select = sel_q;
  assign bin    = disp[DIGIT_W*sel_q +: DIGIT_W];
  assign blank  = lz_blank_en && is_lead_zero(disp, sel_q);

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic        lz_blank_en;
  logic [3:0]  bin;
  logic [1:0]  select;
  logic        blank;
  logic        digit_tick;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  display_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .value       (value),
    .load        (load),
    .lz_blank_en (lz_blank_en),
    .bin         (bin),
    .select      (select),
    .blank       (blank),
    .digit_tick  (digit_tick),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int s);
    return v[4*s +: 4];
  endfunction

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  // Advance until frame_done is seen (bounded); leaves us at select=0, count=0.
  task automatic wait_frame(input string who);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    tests++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL %s wait_frame: frame_done=%b after %0d cycles, required 1", who, frame_done, n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; enable = 1'b1; load = 1'b1; value = 16'hFFFF; lz_blank_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({select, bin, blank, digit_tick, frame_done} !== 9'd0) begin
        fails++;
        $display("FAIL reset[%0d]: sel=%0d bin=%h blank=%b tick=%b fd=%b, required all 0",
                 i, select, bin, blank, digit_tick, frame_done);
      end
    end
    rst_n = 1'b1;
    load  = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (digit_tick !== 1'b1 && n < 20);
    tests++;
    if (n != 4 || digit_tick !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_tick: tick after %0d clks (tick=%b), required 4", n, digit_tick);
    end
    tests++;
    if (select !== 2'd1 || bin !== 4'h0) begin
      fails++;
      $display("FAIL reset_after_tick: sel=%0d bin=%h, required sel=1 bin=0", select, bin);
    end
  endtask

  task automatic test_scan();
    int s;
    do_load(16'h1234);
    wait_frame("scan");
    tests++;
    if (select !== 2'd0 || bin !== 4'h4) begin
      fails++;
      $display("FAIL scan_start: sel=%0d bin=%h, required sel=0 bin=4", select, bin);
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      s = (k / 4) % 4;
      tests++;
      if (select !== 2'(s) || bin !== nib(16'h1234, s) ||
          digit_tick !== (k % 4 == 0) || frame_done !== (k % 16 == 0)) begin
        fails++;
        $display("FAIL scan[%0d]: sel=%0d bin=%h tick=%b fd=%b, required sel=%0d bin=%h tick=%b fd=%b",
                 k, select, bin, digit_tick, frame_done, s, nib(16'h1234, s), (k % 4 == 0), (k % 16 == 0));
      end
    end
  endtask

  task automatic test_deferred();
    int p, s;
    logic [3:0] e;
    for (int i = 0; i < 4; i++) step();
    do_load(16'hABCD);                   // loaded while select=1
    for (int i = 1; i <= 11; i++) begin
      step();
      p = 5 + i;
      s = (p / 4) % 4;
      e = (p < 16) ? nib(16'h1234, s) : nib(16'hABCD, 0);
      tests++;
      if (bin !== e || frame_done !== (p == 16)) begin
        fails++;
        $display("FAIL deferred[%0d]: bin=%h fd=%b, required bin=%h fd=%b", p, bin, frame_done, e, (p == 16));
      end
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      s = (k / 4) % 4;
      tests++;
      if (bin !== nib(16'hABCD, s)) begin
        fails++;
        $display("FAIL deferred_next[%0d]: bin=%h, required %h", k, bin, nib(16'hABCD, s));
      end
    end
  endtask

  task automatic test_boundary();
    int s;
    for (int i = 0; i < 15; i++) step();
    tests++;
    if (select !== 2'd3 || bin !== 4'hA) begin
      fails++;
      $display("FAIL boundary_pre: sel=%0d bin=%h, required sel=3 bin=a", select, bin);
    end
    do_load(16'h5678);                   // terminal count of select=3
    tests++;
    if (frame_done !== 1'b1 || select !== 2'd0 || bin !== 4'h8) begin
      fails++;
      $display("FAIL boundary_bypass: fd=%b sel=%0d bin=%h, required fd=1 sel=0 bin=8", frame_done, select, bin);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      s = (k / 4) % 4;
      tests++;
      if (bin !== nib(16'h5678, s)) begin
        fails++;
        $display("FAIL boundary_frame[%0d]: bin=%h, required %h", k, bin, nib(16'h5678, s));
      end
    end
    for (int i = 0; i < 14; i++) step();
    do_load(16'h9999);
    do_load(16'h5678);
    for (int k = 0; k < 16; k++) begin
      s = (k / 4) % 4;
      tests++;
      if (bin !== nib(16'h5678, s)) begin
        fails++;
        $display("FAIL boundary_b2b[%0d]: bin=%h, required %h", k, bin, nib(16'h5678, s));
      end
      step();
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_tbl [3];
    exp_tbl[0] = 4'b1100;                // 0x0042, enabled
    exp_tbl[1] = 4'b1110;                // 0x0000, enabled
    exp_tbl[2] = 4'b0000;                // 0x0000, disabled
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin
        do_load(16'h0042);
        wait_frame("blank0042");
      end else if (c == 1) begin
        do_load(16'h0000);
        wait_frame("blank0000");
      end
      lz_blank_en = (c != 2);
      for (int k = 0; k < 16; k++) begin
        tests++;
        if (blank !== exp_tbl[c][k/4]) begin
          fails++;
          $display("FAIL blank[%0d][%0d]: sel=%0d blank=%b, required %b", c, k, select, blank, exp_tbl[c][k/4]);
        end
        step();
      end
    end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_enable();
    do_load(16'hCAFE);
    wait_frame("enable_sync");
    for (int i = 0; i < 9; i++) step();  // select=2, prescaler=1
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load  = (i == 3);
      value = 16'h4321;
      step();
      tests++;
      if (select !== 2'd2 || bin !== 4'hA || digit_tick !== 1'b0 || frame_done !== 1'b0) begin
        fails++;
        $display("FAIL enable_hold[%0d]: sel=%0d bin=%h tick=%b fd=%b, required sel=2 bin=a tick=0 fd=0",
                 i, select, bin, digit_tick, frame_done);
      end
    end
    load   = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (digit_tick !== (i == 3) || select !== ((i == 3) ? 2'd3 : 2'd2)) begin
        fails++;
        $display("FAIL enable_resume[%0d]: tick=%b sel=%0d, required tick=%b sel=%0d",
                 i, digit_tick, select, (i == 3), (i == 3) ? 3 : 2);
      end
    end
    wait_frame("enable_load");
    tests++;
    if (bin !== 4'h1) begin
      fails++;
      $display("FAIL enable_load: bin=%h, required 1", bin);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_deferred();
    test_boundary();
    test_blank();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
